// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader
// Writable 16 x 46-bit program store for the MCX core. A byte-serial image
// arrives over a valid/ready handshake. The loader assembles it into lines
// and keeps the core in reset until a complete, well-formed image is present.
//
// Image format: header byte N (1..16), then N lines of 6 bytes each, MSB
// first. The top two bits of the first byte of every line must be zero.
//
// Optional build macro: LOADER_CHECKSUM_EN. When it is defined, one trailing
// byte follows the data. It must equal the 8-bit wrapping sum of the header
// and all data bytes.
//
// Ports
//   clk           system clock, rising edge
//   nrst          synchronous active-low reset
//   ld_start      one-cycle pulse: begin a new image load
//   ld_data       image byte
//   ld_valid      ld_data valid
//   ld_ready      loader accepts a byte this cycle (registered)
//   ld_done       image loaded successfully (sticky)
//   ld_err        image rejected (sticky)
//   cpu_hold      core held in reset while 1
//   addr          core fetch address
//   line          instruction line at addr, 0 while cpu_hold=1
//   lines_loaded  lines written in the current or last load
//
// state | meaning
// IDLE  | after reset, waiting for ld_start
// HDR   | expecting the line-count byte
// DATA  | receiving 6-byte lines
// CHK   | expecting the checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | image valid, core released
// ERR   | image rejected, core held, reads forced to 0

module prog_loader #(
  parameter int LINES  = 16,
  parameter int LINE_W = 46,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ld_start,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              cpu_hold,
  input  logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] line,
  output logic [4:0]        lines_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [LINE_W-1:0] store_q [LINES];
  logic [4:0]        n_q;
  logic [4:0]        lines_q;
  logic [2:0]        bcnt_q;
  // Bytes 0..4 of the current line: 6 + 4*8 = 38 bits. Byte 5 completes it.
  logic [37:0]       acc_q;
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic              hold_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic              accept;
  logic [LINE_W-1:0] line_d;
  logic [4:0]        lines_d;

  assign accept  = ld_valid & ready_q;
  assign line_d  = {acc_q, ld_data};
  assign lines_d = lines_q + 5'd1;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < LINES; i++) store_q[i] <= '0;
      n_q     <= '0;
      lines_q <= '0;
      bcnt_q  <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          // ld_ready is 0 here, so a byte presented together with the start
          // pulse is not consumed.
          if (ld_start) begin
            for (int i = 0; i < LINES; i++) store_q[i] <= '0;
            lines_q <= '0;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            ready_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
            state_q <= S_HDR;
          end
        end

        S_HDR: begin
          if (accept) begin
            if (ld_data == 8'd0 || ld_data > 8'd16) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              n_q     <= ld_data[4:0];
`ifdef LOADER_CHECKSUM_EN
              sum_q   <= sum_q + ld_data;
`endif
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            if (bcnt_q == 3'd0 && ld_data[7:6] != 2'b00) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              ready_q <= 1'b0;
            end else begin
`ifdef LOADER_CHECKSUM_EN
              sum_q <= sum_q + ld_data;
`endif
              if (bcnt_q == 3'd5) begin
                store_q[lines_q[ADDR_W-1:0]] <= line_d;
                lines_q <= lines_d;
                bcnt_q  <= '0;
                if (lines_d == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q <= S_CHK;
`else
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  hold_q  <= 1'b0;
                  ready_q <= 1'b0;
`endif
                end
              end else begin
                bcnt_q <= bcnt_q + 3'd1;
                if (bcnt_q == 3'd0) acc_q <= {32'd0, ld_data[5:0]};
                else                acc_q <= {acc_q[29:0], ld_data};
              end
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (ld_data == sum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ld_ready     = ready_q;
  assign ld_done      = done_q;
  assign ld_err       = err_q;
  assign cpu_hold     = hold_q;
  assign lines_loaded = lines_q;
  // Reads are blanked while the core is held, which also hides the store
  // contents after a rejected image.
  assign line         = hold_q ? '0 : store_q[addr];

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_data = 8'd0;
  logic        ld_valid = 1'b0;
  logic        ld_ready, ld_done, ld_err, cpu_hold;
  logic [3:0]  addr = 4'd0;
  logic [45:0] line;
  logic [4:0]  lines_loaded;

  prog_loader dut (
    .clk(clk), .nrst(nrst), .ld_start(ld_start), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done),
    .ld_err(ld_err), .cpu_hold(cpu_hold), .addr(addr), .line(line),
    .lines_loaded(lines_loaded)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [45:0] img [16];
  logic [45:0] exp_line [16];
  bit          gaps_on = 1'b0;
  int          glitch_idx = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every task below is entered and left at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int budget;
    if (gaps_on) begin
      repeat ($urandom_range(0, 3)) begin
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    ld_data  = b;
    ld_valid = 1'b1;
    budget   = 0;
    while (ld_ready !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (ld_ready !== 1'b1) begin
      check("ready_timeout", 64'(ld_ready), 64'd1);
      ld_valid = 1'b0;
      return;
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int k = 0; k < 16; k++) exp_line[k] = '0;
  endtask

  // Sends header n plus lines img[0..n-1] (and the checksum when built with
  // it). The model expects those lines at their index and 0 elsewhere.
  task automatic send_image(input int n);
    int          sum;
    int          idx;
    logic [47:0] v;
    logic [7:0]  b;
    sum = n;
    idx = 0;
    if (glitch_idx == idx) pulse_start();
    send_byte(8'(n));
    for (int k = 0; k < n; k++) begin
      v = {2'b00, img[k]};
      for (int j = 0; j < 6; j++) begin
        idx++;
        b   = 8'(v >> (8 * (5 - j)));
        sum = sum + int'(b);
        if (glitch_idx == idx) begin
          ld_start = 1'b1;
          @(negedge clk);
          ld_start = 1'b0;
        end
        send_byte(b);
      end
      exp_line[k] = img[k];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'(sum % 256));
`endif
  endtask

  task automatic check_store(input string tag, input bit hold_exp);
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      check(tag, 64'(line), hold_exp ? 64'd0 : 64'(exp_line[a]));
    end
    @(negedge clk);
  endtask

  task automatic expect_done(input int n);
    check("done",         64'(ld_done), 64'd1);
    check("done_err",     64'(ld_err), 64'd0);
    check("done_hold",    64'(cpu_hold), 64'd0);
    check("done_ready",   64'(ld_ready), 64'd0);
    check("done_nlines",  64'(lines_loaded), 64'(n));
    check_store("done_line", 1'b0);
  endtask

  task automatic expect_err(input int n);
    check("err",          64'(ld_err), 64'd1);
    check("err_done",     64'(ld_done), 64'd0);
    check("err_hold",     64'(cpu_hold), 64'd1);
    check("err_ready",    64'(ld_ready), 64'd0);
    check("err_nlines",   64'(lines_loaded), 64'(n));
    check_store("err_line", 1'b1);
  endtask

  task automatic random_lines(input int n);
    logic [63:0] r;
    for (int k = 0; k < n; k++) begin
      r = {$urandom, $urandom};
      img[k] = r[45:0];
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 16; k++) exp_line[k] = '0;

    // Reset and idle, including a stray byte that must be ignored.
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("rst_ready",  64'(ld_ready), 64'd0);
    check("rst_hold",   64'(cpu_hold), 64'd1);
    check("rst_done",   64'(ld_done), 64'd0);
    check("rst_err",    64'(ld_err), 64'd0);
    check("rst_nlines", 64'(lines_loaded), 64'd0);
    ld_valid = 1'b1; ld_data = 8'h01;
    repeat (3) @(negedge clk);
    ld_valid = 1'b0;
    check("idle_ready", 64'(ld_ready), 64'd0);
    check_store("rst_line", 1'b1);

    // Single all-ones line.
    pulse_start();
    check("hdr_ready", 64'(ld_ready), 64'd1);
    img[0] = 46'h3FFF_FFFF_FFFF;
    send_image(1);
    expect_done(1);

    // Start together with a 00 byte from DONE: the byte must not be taken as
    // a header, otherwise the load below is rejected.
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h00;
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b0;
    for (int k = 0; k < 16; k++) exp_line[k] = '0;
    check("coll_err",   64'(ld_err), 64'd0);
    check("coll_ready", 64'(ld_ready), 64'd1);
    check("coll_done",  64'(ld_done), 64'd0);

    // Full 16-line image with gaps and an ignored mid-load ld_start.
    for (int k = 0; k < 16; k++) img[k] = {4'(k + 1), 2'b01, 4'h3, 36'(k)};
    gaps_on = 1'b1;
    glitch_idx = 40;
    send_image(16);
    glitch_idx = -1;
    expect_done(16);

    // Random images.
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 16);
      random_lines(n);
      pulse_start();
      send_image(n);
      expect_done(n);
    end

    // Bad headers, then recovery.
    pulse_start();
    send_byte(8'h00);
    expect_err(0);
    pulse_start();
    send_byte(8'h11);
    expect_err(0);
    random_lines(1);
    pulse_start();
    send_image(1);
    expect_done(1);

    // Bad first byte of a line.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h40);
    expect_err(0);
    random_lines(1);
    pulse_start();
    send_byte(8'h02);
    for (int j = 0; j < 6; j++) send_byte(8'(({2'b00, img[0]}) >> (8 * (5 - j))));
    send_byte(8'h80);
    expect_err(1);

    // Partial 4-line load stalls, then nrst aborts it.
    random_lines(4);
    pulse_start();
    send_byte(8'h04);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 6; j++) send_byte(8'(({2'b00, img[k]}) >> (8 * (5 - j))));
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    repeat (20) @(negedge clk);
    check("part_nlines", 64'(lines_loaded), 64'd2);
    check("part_ready",  64'(ld_ready), 64'd1);
    check("part_done",   64'(ld_done), 64'd0);
    check("part_hold",   64'(cpu_hold), 64'd1);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) exp_line[k] = '0;
    check("abort_ready",  64'(ld_ready), 64'd0);
    check("abort_nlines", 64'(lines_loaded), 64'd0);
    check("abort_done",   64'(ld_done), 64'd0);
    check("abort_hold",   64'(cpu_hold), 64'd1);
    check_store("abort_line", 1'b1);

`ifdef LOADER_CHECKSUM_EN
    gaps_on = 1'b0;
    pulse_start();
    send_byte(8'h01);
    for (int j = 1; j <= 6; j++) send_byte(8'(j));
    send_byte(8'h16);
    exp_line[0] = 46'h01_0203_0405_06;
    expect_done(1);
    pulse_start();
    send_byte(8'h01);
    for (int j = 1; j <= 6; j++) send_byte(8'(j));
    send_byte(8'h17);
    expect_err(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
